// File: rtl/seq_multplr_param_if.sv
// Handshake/data bundle for seq_multplr_param: start/operands in, busy/done/product out.
interface seq_multplr_param_if #(
  parameter int WIDTH = 8
);
  logic               start;
  logic               sgn;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] p;

  modport master (output start, sgn, a, b, input busy, done, p);
  modport slave  (input start, sgn, a, b, output busy, done, p);
endinterface

// File: rtl/seq_multplr_param.sv
// Sequential shift-add multiplier (unsigned or two's-complement) with start/done handshake.
// Optional macro SEQ_MULTPLR_EARLY_DONE_EN finishes as soon as no multiplicand bits remain.
module seq_multplr_param #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               clr_n,
  seq_multplr_param_if.slave bus
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   a_reg, acc, p_reg, t;
  logic [WIDTH-1:0] b_reg;
  logic [CW-1:0]   cnt;
  logic            sgn_reg;
  logic            done_reg;
  logic            last;
  logic            finish;

  // Partial-product step; the MSB of a signed multiplicand carries negative weight.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    t = acc;
    if (b_reg[0]) begin
      if (sgn_reg && (cnt == LAST_CNT)) t = acc - a_reg;
      else                              t = acc + a_reg;
    end
  end

`ifdef SEQ_MULTPLR_EARLY_DONE_EN
  assign last = (cnt == LAST_CNT) || ((b_reg >> 1) == '0);
`else
  assign last = (cnt == LAST_CNT);
`endif

  // State register.
  always_ff @(posedge clk or negedge clr_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!clr_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last)      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode; done itself is registered below so outputs stay input-independent.
  always_comb begin
    bus.busy = (state_q == RUN);
    finish   = (state_q == RUN) && last;
  end

  // Datapath.
  always_ff @(posedge clk or negedge clr_n) begin
    // NOTE: every register here is reset so an aborted operation leaves no stale state.
    if (!clr_n) begin
      a_reg    <= '0;
      b_reg    <= '0;
      acc      <= '0;
      cnt      <= '0;
      sgn_reg  <= 1'b0;
      p_reg    <= '0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= finish;
      if (state_q == IDLE) begin
        if (bus.start) begin
          a_reg   <= {{WIDTH{bus.a[WIDTH-1] & bus.sgn}}, bus.a};
          b_reg   <= bus.b;
          sgn_reg <= bus.sgn;
          acc     <= '0;
          cnt     <= '0;
        end
      end else begin
        acc   <= t;
        a_reg <= a_reg << 1;
        b_reg <= b_reg >> 1;
        cnt   <= cnt + 1'b1;
        if (finish) p_reg <= t;
      end
    end
  end

  assign bus.done = done_reg;
  assign bus.p    = p_reg;
endmodule

// File: tb/tb_seq_multplr_param.sv
// Self-checking bench for seq_multplr_param: cycle-level reference model plus directed cases.
module tb_seq_multplr_param;
  localparam int W = 8;
`ifdef SEQ_MULTPLR_EARLY_DONE_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic clr_n = 1'b0;
  always #5 clk = ~clk;

  seq_multplr_param_if #(.WIDTH(W)) bus ();
  seq_multplr_param #(.WIDTH(W)) dut (.clk(clk), .clr_n(clr_n), .bus(bus));

  int checks = 0;
  int errors = 0;
  int cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: product from plain modular arithmetic, latency from the top set bit of b.
  function automatic logic [2*W-1:0] product(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic s);
    logic [2*W-1:0] ax, bx;
    ax = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    bx = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    return ax * bx;
  endfunction

  function automatic int latency(input logic [W-1:0] b);
    if (!EARLY) return W;
    for (int i = W - 1; i >= 0; i--) if (b[i]) return i + 1;
    return 1;
  endfunction

  logic           m_busy, m_done;
  logic [2*W-1:0] m_p, m_prod;
  int             m_left;

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_p    <= '0;
      m_prod <= '0;
      m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (!m_busy) begin
        if (bus.start) begin
          m_busy <= 1'b1;
          m_prod <= product(bus.a, bus.b, bus.sgn);
          m_left <= latency(bus.b);
        end
      end else if (m_left == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_p    <= m_prod;
      end else begin
        m_left <= m_left - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (clr_n) begin
      check("busy", 32'(bus.busy), 32'(m_busy));
      check("done", 32'(bus.done), 32'(m_done));
      check("p",    32'(bus.p),    32'(m_p));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.sgn   = s;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    cyc = 0;
  endtask

  task automatic wait_done(input string name, input logic [2*W-1:0] exp_p, input int exp_lat);
    while (!bus.done && cyc < 3 * W) tick();
    check({name, "_lat"}, 32'(cyc), 32'(exp_lat));
    check({name, "_p"}, 32'(bus.p), 32'(exp_p));
  endtask

  initial begin
    int dones;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.sgn   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_p",    32'(bus.p),    32'd0);
    clr_n = 1'b1;
    @(negedge clk);

    start_op(8'd13, 8'd11, 1'b0);
    wait_done("u13x11", 16'h008F, EARLY ? 4 : 8);
    @(negedge clk);
    start_op(8'hFD, 8'd5, 1'b1);
    wait_done("sm3x5", 16'hFFF1, EARLY ? 3 : 8);
    @(negedge clk);
    start_op(8'h80, 8'h80, 1'b1);
    wait_done("s80x80", 16'h4000, 8);
    @(negedge clk);
    start_op(8'hFF, 8'hFF, 1'b0);
    wait_done("uFFxFF", 16'hFE01, 8);
    start_op(8'd2, 8'd3, 1'b0);          // accepted in the done cycle
    wait_done("b2b_2x3", 16'h0006, EARLY ? 2 : 8);
    @(negedge clk);

    start_op(8'd7, 8'd9, 1'b0);
    tick();
    tick();
    bus.start = 1'b1;
    bus.a     = 8'd1;
    bus.b     = 8'd1;
    tick();
    bus.start = 1'b0;
    wait_done("ign_7x9", 16'h003F, EARLY ? 4 : 8);
    dones = 0;
    repeat (12) begin
      tick();
      if (bus.done) dones++;
    end
    check("ign_extra_done", 32'(dones), 32'd0);

    start_op(8'd10, 8'd3, 1'b0);
    wait_done("e10x3", 16'd30, EARLY ? 2 : 8);
    @(negedge clk);
    start_op(8'd77, 8'd0, 1'b0);
    wait_done("e77x0", 16'd0, EARLY ? 1 : 8);
    @(negedge clk);

    start_op(8'h55, 8'hFF, 1'b0);
    tick();
    tick();
    tick();
    @(posedge clk);
    #2;
    clr_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_p",    32'(bus.p),    32'd0);
    @(negedge clk);
    clr_n = 1'b1;
    dones = 0;
    repeat (12) begin
      tick();
      if (bus.done) dones++;
    end
    check("abort_no_done", 32'(dones), 32'd0);

    // Random traffic: start pulses land in IDLE, RUN and done cycles alike.
    @(negedge clk);
    for (int i = 0; i < 3000; i++) begin
      bus.start = ($urandom_range(0, 3) == 0);
      bus.a     = W'($urandom);
      bus.b     = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 7)) : W'($urandom);
      bus.sgn   = $urandom_range(0, 1) == 1;
      @(negedge clk);
    end
    bus.start = 1'b0;
    repeat (3 * W) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_multplr_param.md
# seq_multplr_param

Parametrised sequential shift-add multiplier with an integrated controller and a start/done handshake. It multiplies two `WIDTH`-bit operands and produces a `2*WIDTH`-bit product. The operands are unsigned or two's-complement, selected per operation. It replaces the fixed 4-bit split controller/datapath multiplier pair and serves as the shared multiplier for datapaths that can tolerate multi-cycle latency.

## Interface
- `WIDTH`, default 8: operand width; legal range is 2 or more.
- `clk`, input, 1: clock; all state updates on the rising edge.
- `clr_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: request a new multiply; sampled only in IDLE.
- `sgn`, input, 1: 1 means `a` and `b` are two's-complement; 0 means unsigned. Captured with `start`.
- `a`, input, `WIDTH`: multiplier; captured with `start`.
- `b`, input, `WIDTH`: multiplicand; captured with `start`. Its bits are scanned LSB-first.
- `busy`, output, 1: high while in RUN.
- `done`, output, 1: one-cycle pulse when `p` takes a new product.
- `p`, output, `2*WIDTH`: product register.

## Operation
- **Reset values:** `busy`=0, `done`=0, `p`=0. The FSM is in IDLE and all internal registers are 0.
- **States:** IDLE and RUN. `busy` = (state == RUN).
- **IDLE, with `start`=1 at an edge:**
  - Load `a_reg` with `a` extended to `2*WIDTH` bits: sign-extended if `sgn`=1, zero-extended otherwise.
  - Load `b_reg` with `b`.
  - Capture `sgn`. Clear the accumulator `acc` and the bit counter `cnt`. Go to RUN.
- **IDLE, with `start`=0:** no state change.
- **RUN, each edge (bit index `cnt`):**
  - Compute `t = acc + a_reg` if `b_reg[0]`=1, else `t = acc`.
  - Exception: when `sgn`=1, `cnt`==`WIDTH`-1 and `b_reg[0]`=1, compute `t = acc - a_reg` instead (the MSB has negative weight).
  - Update `acc` to `t`, `a_reg` to `a_reg << 1`, `b_reg` to `b_reg >> 1` (logical shift), and `cnt` to `cnt + 1`.
  - All arithmetic is modulo 2^(2*WIDTH).
- **Completion:** at the RUN edge where `cnt`==`WIDTH`-1 (or the early condition, see Configuration):
  - Load `p` with `t`.
  - Set `done` to 1 for exactly one cycle.
  - Go to IDLE.
- **Output hold:** `p` holds the previous product throughout RUN and changes only at completion.
- **`start` while busy:** `start` in RUN is ignored. It is neither queued nor does it disturb the operation in progress.
- **Back-to-back operations:** `start` is accepted in the cycle where `done`=1, because the FSM is already in IDLE.
- **Reset mid-operation:** asserting `clr_n`=0 in RUN aborts immediately. All outputs return to their reset values and no `done` is issued.
- **Input stability:** the inputs `a`, `b` and `sgn` are don't-care outside the `start` capture edge.

## Timing
- `start` is sampled at edge E0. `busy` rises after E0.
- Without early termination, completion happens at edge E0+`WIDTH`. `done` and the new `p` are visible after that edge, and `busy` falls at the same edge.
- Latency from the `start` sample to `done` is `WIDTH` cycles. Issue rate is one multiply per `WIDTH`+1 cycles.
- `done` is registered; there is no combinational path from any input to any output.

## Configuration
- Macro: `SEQ_MULTPLR_EARLY_DONE_EN`.
- **Defined:** in RUN, completion also occurs at any edge where `(b_reg >> 1) == 0`, i.e. no set bits remain to be processed. `p`/`done` behave as for normal completion.
  - Latency becomes (index of the highest set bit of `b`) + 1. The minimum is 1 cycle, when `b` = 0 or `b` = 1.
  - In signed mode a negative `b` has its MSB set, so it always takes `WIDTH` cycles.
- **Undefined:** latency is always exactly `WIDTH` cycles, independent of the operand values.

## Test plan
All scenarios use `WIDTH`=8.
- **Unsigned:** `a`=13, `b`=11, `sgn`=0 → `done` 8 cycles after the start edge, `p`=16'h008F. `busy` is high for 8 cycles.
- **Signed:** `a`=-3 (8'hFD), `b`=5, `sgn`=1 → `p`=16'hFFF1. Also `a`=b=8'h80, `sgn`=1 → `p`=16'h4000.
- **Unsigned extremes:** `a`=b=8'hFF, `sgn`=0 → `p`=16'hFE01. Then `start` in the `done` cycle with `a`=2, `b`=3 → `p`=16'h0006 after a further 8 cycles.
- **Ignored start:** `a`=7, `b`=9 started; `start` pulsed again in RUN cycle 3 with `a`=1, `b`=1 → a single `done`, `p`=16'h003F.
- **Reset mid-operation:** `clr_n` low in RUN cycle 4 → `busy`=0, `done`=0, `p`=0. No `done` follows.
- **Early done, with `SEQ_MULTPLR_EARLY_DONE_EN`:**
  - `b`=3, `a`=10 → `done` 2 cycles after start, `p`=30.
  - `b`=0 → `done` after 1 cycle, `p`=0.
  - Without the macro, both cases take 8 cycles.
